// File: rtl/mattvenn_spi_test.sv
// mattvenn_spi_test: SPI mode-0 slave in front of an 8x8-bit register bank.
// The SPI pins are oversampled in the clk domain. reg0 drives uo_out, and reg7
// is a read-only ID register. The bench clocks SCLK at 1/12 of clk; fclk must
// be at least 8x fSCLK.
module mattvenn_spi_test #(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [7:0]  ID_VALUE = 8'h96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,     // CS_n high
    ST_CMD,      // shifting in R/W + address
    ST_RD_DATA,  // driving read data on MISO
    ST_TAIL      // write data phase or post-frame; MISO held low
  } state_t;

  // Synchronizers and edge detection
  logic       r_cs_meta, r_cs_sync;
  logic       r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic       r_mosi_meta, r_mosi_sync;
  logic       w_rise, w_fall;

  // Frame datapath
  logic [4:0]  r_cnt;
  logic [14:0] r_rx;
  logic [15:0] w_frame;
  logic [7:0]  w_byte0;
  logic [AW-1:0] r_addr;
  logic        r_rw;
  logic        w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [7:0]  w_rd_data;
  logic [7:0]  r_miso_shift;
  logic [7:0]  r_regs [NUM_REGS-1];
  logic [7:0]  r_uo;
  logic        w_miso;
  logic        w_unused;

  state_t r_state, w_state_next;

  // 2-FF synchronizers for CS_n, SCLK and MOSI, plus previous SCLK sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_cs_meta   <= ui_in[0];
      r_cs_sync   <= r_cs_meta;
      r_sclk_meta <= ui_in[1];
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_meta <= ui_in[2];
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_rise = ~r_cs_sync &  r_sclk_sync & ~r_sclk_prev;
  assign w_fall = ~r_cs_sync & ~r_sclk_sync &  r_sclk_prev;

  // Bits as they would look once the bit arriving this cycle is shifted in
  assign w_frame = {r_rx, r_mosi_sync};
  assign w_byte0 = {r_rx[6:0], r_mosi_sync};

  assign w_wr_en   = w_rise && (r_cnt == 5'd15) && w_frame[15];
  assign w_wr_addr = w_frame[8 +: AW];

  // Bit counter and receive shift register; both clear while deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rx  <= '0;
    end else if (r_cs_sync) begin
      r_cnt <= '0;
      r_rx  <= '0;
    end else if (w_rise && (r_cnt != 5'd16)) begin
      r_cnt <= r_cnt + 5'd1;
      r_rx  <= w_frame[14:0];
    end
  end

  // Latch R/W and read address at the 8th rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rw   <= 1'b0;
    end else if (w_rise && (r_cnt == 5'd7)) begin
      r_addr <= w_byte0[AW-1:0];
      r_rw   <= w_byte0[7];
    end
  end

  // Register bank write; reg7 has no storage, so writes to it fall through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++)
        if (w_wr_addr == AW'(i)) r_regs[i] <= w_frame[7:0];
    end
  end

  // Read mux: the top address returns the ID constant
  always_comb begin
    w_rd_data = ID_VALUE;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++)
      if (r_addr == AW'(i)) w_rd_data = r_regs[i];
  end

  // Frame phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Frame phase sequencing: read data phase runs from 8th to 16th falling edge
  always_comb begin
    w_state_next = r_state;
    if (r_cs_sync) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    w_state_next = ST_CMD;
        ST_CMD:     if (w_fall && (r_cnt == 5'd8))
                      w_state_next = r_rw ? ST_TAIL : ST_RD_DATA;
        ST_RD_DATA: if (w_fall && (r_cnt == 5'd16)) w_state_next = ST_TAIL;
        ST_TAIL:    w_state_next = ST_TAIL;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // MISO shifter: load at the 8th falling edge, shift on later falling edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_shift <= '0;
    end else if (r_cs_sync) begin
      r_miso_shift <= '0;
    end else if (w_fall) begin
      if ((r_state == ST_CMD) && (r_cnt == 5'd8) && !r_rw)
        r_miso_shift <= w_rd_data;
      else if (r_state == ST_RD_DATA)
        r_miso_shift <= {r_miso_shift[6:0], 1'b0};
    end
  end

  // uo_out mirrors reg0 one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_uo <= '0;
    else        r_uo <= r_regs[0];
  end

  assign w_miso  = (r_state == ST_RD_DATA) & r_miso_shift[7];
  assign uo_out  = r_uo;
  assign uio_out = {7'b0, w_miso};
  assign uio_oe  = 8'h01;

  assign w_unused = &{1'b0, ena, ui_in[7:3], uio_in, w_frame, w_byte0};

endmodule

// File: tb/tb_mattvenn_spi_test.sv
// Randomized SPI frame bench for mattvenn_spi_test with an array-based
// register model; SCLK half period is 6 clk cycles.
module tb_mattvenn_spi_test;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_errors;
  logic [7:0] m_regs [8];

  mattvenn_spi_test #(.NUM_REGS(8), .ID_VALUE(8'h96)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
  endfunction

  // Send the first n bits of a frame (bits past 16 are random filler)
  task automatic spi_xfer(input logic [15:0] frame, input int n);
    logic       rw;
    logic [2:0] addr;
    logic [7:0] exp_rd;
    logic [7:0] got_rd;
    logic       cmd_miso;
    logic       b;
    rw     = frame[15];
    addr   = frame[10:8];
    exp_rd = (addr == 3'd7) ? 8'h96 : m_regs[addr];
    if (n >= 16 && rw && addr != 3'd7) m_regs[addr] = frame[7:0];
    got_rd   = 8'h00;
    cmd_miso = 1'b0;
    ui_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i < 16) b = frame[15-i];
      else        b = 1'($urandom);
      ui_in[2] = b;
      repeat (6) @(negedge clk);
      if (i < 8)       cmd_miso = cmd_miso | uio_out[0];
      else if (i < 16) got_rd = {got_rd[6:0], uio_out[0]};
      ui_in[1] = 1'b1;
      repeat (4) @(negedge clk);
      if (i == 15) check("uo_out_4clk", {24'd0, uo_out}, {24'd0, m_regs[0]});
      repeat (2) @(negedge clk);
      ui_in[1] = 1'b0;
    end
    repeat (6) @(negedge clk);
    ui_in[0] = 1'b1;
    ui_in[2] = 1'b0;
    repeat (8) @(negedge clk);
    if (n >= 16 && !rw) begin
      check("miso_cmd_phase", {31'd0, cmd_miso}, 32'd0);
      check($sformatf("miso_rd_a%0d", addr), {24'd0, got_rd}, {24'd0, exp_rd});
    end
    check("uo_out", {24'd0, uo_out}, {24'd0, m_regs[0]});
    check("miso_idle", {24'd0, uio_out}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ena      = 1'b1;
    uio_in   = 8'h00;
    ui_in    = 8'h01;
    rst_n    = 1'b0;
    model_clear();

    // reset state
    #1;
    check("rst_uo", {24'd0, uo_out}, 32'd0);
    check("rst_uio_out", {24'd0, uio_out}, 32'd0);
    check("rst_uio_oe", {24'd0, uio_oe}, 32'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_uo", {24'd0, uo_out}, 32'd0);
    check("idle_uio_out", {24'd0, uio_out}, 32'd0);

    // writes to reg0
    spi_xfer(16'h80A5, 16);
    spi_xfer(16'h803C, 16);
    // write/readback
    spi_xfer(16'h835A, 16);
    spi_xfer(16'h0300, 16);
    // ID register, write ignored
    spi_xfer(16'h0700, 16);
    spi_xfer(16'h87FF, 16);
    spi_xfer(16'h0700, 16);
    // abort after 10 bits, then a full frame
    spi_xfer(16'h8077, 10);
    spi_xfer(16'h8011, 16);
    // address alias and overrun
    spi_xfer(16'hF942, 16);
    spi_xfer(16'h0100, 16);
    spi_xfer(16'h8233, 20);
    spi_xfer(16'h0200, 16);

    // randomized frames: mix of writes, reads, aborts and overruns
    for (int k = 0; k < 40; k++) begin
      logic [15:0] f;
      int          len;
      int          sel;
      f   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = $urandom_range(1, 15);
      else if (sel == 1) len = $urandom_range(17, 20);
      else               len = 16;
      spi_xfer(f, len);
    end

    // readback of every address
    for (int a = 0; a < 8; a++) spi_xfer({5'b00000, 3'(a), 8'h00}, 16);

    // asynchronous reset clears the bank at once
    spi_xfer(16'h80E7, 16);
    spi_xfer(16'h8155, 16);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("midrst_uo", {24'd0, uo_out}, 32'd0);
    check("midrst_uio_oe", {24'd0, uio_oe}, 32'h01);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_xfer(16'h0100, 16);
    spi_xfer(16'h0000, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
